packet_builder: RTL and testbench

- Transmit-side counterpart of the sequence parser.
- Accepts one message per handshake (stream ID plus up to 32 payload bytes) and assigns the next per-stream sequence number.
- Serializes the packet onto the 32-bit valid/ready/last word interface that the parser consumes.
- Wire format: word0 = {length LE, stream LE}; word1 = seq LE; then payload words. Byte 0 of every word is bits [31:24].

---
 rtl/packet_builder.sv | 159 +++++++++++++++
 tb/tb_packet_builder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_builder.sv
// packet_builder: accepts one message (stream ID + payload) per handshake,
// assigns the next per-stream sequence number and serializes the packet as
// 32-bit words: header {len LE, stream LE}, seq LE, then payload words.
module packet_builder #(
    parameter int NUM_STREAMS = 16,
    parameter int MAX_PAYLOAD = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       msg_val,
    output logic                       msg_ready,
    input  logic [15:0]                msg_stream,
    input  logic [5:0]                 msg_len,
    input  logic [0:8*MAX_PAYLOAD-1]   msg_data,
    output logic [31:0]                dataOut,
    output logic                       dataOut_val,
    input  logic                       dataOut_ready,
    output logic                       dataOut_last,
    output logic                       msg_err
);

    localparam int SW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam int PW = (MAX_PAYLOAD + 3) / 4;           // payload words max
    localparam int IW = (PW > 1) ? $clog2(PW) : 1;

    typedef enum logic [1:0] {IDLE, HDR, SEQ, PAY} state_t;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic [15:0]          stream_q, stream_d;
    logic [5:0]           len_q, len_d;
    logic [0:32*PW-1]     data_q, data_d;    // payload, bytes past len zeroed
    logic [31:0]          seq_q, seq_d;
    logic [IW-1:0]        widx_q, widx_d;
    logic [31:0]          dout_q, dout_d;
    logic                 val_q, val_d;
    logic                 last_q, last_d;
    logic                 err_q, err_d;
    logic [31:0]          next_seq_q [NUM_STREAMS];
    logic [31:0]          next_seq_d [NUM_STREAMS];

    logic                 xfer;
    logic                 bad;
    logic [SW-1:0]        sidx;
    logic [15:0]          len_l;
    logic [IW-1:0]        n_idx;
    logic [31:0]          n_word;
    logic [7:0]           n_end;
    logic                 n_last;

    assign xfer   = val_q && dataOut_ready;
    assign bad    = (msg_stream >= 16'(NUM_STREAMS)) || (int'(msg_len) > MAX_PAYLOAD);
    assign sidx   = msg_stream[SW-1:0];
    assign len_l  = 16'd8 + 16'(msg_len);

    // Next payload word to present: word 0 when leaving SEQ, else the one after widx.
    assign n_idx  = (state_q == SEQ) ? '0 : widx_q + IW'(1);
    assign n_word = data_q[{n_idx, 5'b00000} +: 32];
    assign n_end  = 8'({n_idx, 2'b00}) + 8'd4;
    assign n_last = n_end >= 8'(len_q);

    // Next-state, capture and output-word selection.
    always_comb begin
        state_d    = state_q;
        stream_d   = stream_q;
        len_d      = len_q;
        data_d     = data_q;
        seq_d      = seq_q;
        widx_d     = widx_q;
        dout_d     = dout_q;
        val_d      = val_q;
        last_d     = last_q;
        err_d      = 1'b0;
        next_seq_d = next_seq_q;
        case (state_q)
            IDLE: begin
                if (msg_val && ready_q) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        stream_d = msg_stream;
                        len_d    = msg_len;
                        data_d   = '0;
                        for (int k = 0; k < MAX_PAYLOAD; k++)
                            data_d[8*k +: 8] = (k < int'(msg_len)) ? msg_data[8*k +: 8] : 8'h00;
                        seq_d            = next_seq_q[sidx];
                        next_seq_d[sidx] = next_seq_q[sidx] + 32'd1;
                        state_d = HDR;
                        val_d   = 1'b1;
                        last_d  = 1'b0;
                        dout_d  = {len_l[7:0], len_l[15:8], msg_stream[7:0], msg_stream[15:8]};
                    end
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d = SEQ;
                    dout_d  = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
                    last_d  = (len_q == 6'd0);
                end
            end
            SEQ, PAY: begin
                if (xfer) begin
                    if (last_q) begin
                        state_d = IDLE;
                        val_d   = 1'b0;
                        last_d  = 1'b0;
                        dout_d  = '0;
                    end else begin
                        state_d = PAY;
                        widx_d  = n_idx;
                        dout_d  = n_word;
                        last_d  = n_last;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; counters restart at 1 on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            stream_q <= '0;
            len_q    <= '0;
            data_q   <= '0;
            seq_q    <= '0;
            widx_q   <= '0;
            dout_q   <= '0;
            val_q    <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int s = 0; s < NUM_STREAMS; s++) next_seq_q[s] <= 32'd1;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            stream_q   <= stream_d;
            len_q      <= len_d;
            data_q     <= data_d;
            seq_q      <= seq_d;
            widx_q     <= widx_d;
            dout_q     <= dout_d;
            val_q      <= val_d;
            last_q     <= last_d;
            err_q      <= err_d;
            next_seq_q <= next_seq_d;
        end
    end

    assign msg_ready    = ready_q;
    assign dataOut      = dout_q;
    assign dataOut_val  = val_q;
    assign dataOut_last = last_q;
    assign msg_err      = err_q;

endmodule

// File: tb/tb_packet_builder.sv
// Directed bench for packet_builder with a scoreboard of expected words.
module tb_packet_builder;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           msg_val = 1'b0;
    logic           msg_ready;
    logic [15:0]    msg_stream = '0;
    logic [5:0]     msg_len = '0;
    logic [0:255]   msg_data = '0;
    logic [31:0]    dataOut;
    logic           dataOut_val;
    logic           dataOut_ready = 1'b1;
    logic           dataOut_last;
    logic           msg_err;

    int             checks = 0;
    int             fails = 0;
    int             err_cnt = 0;
    logic [32:0]    q[$];          // {last, word}
    logic [31:0]    got_log[$];
    int unsigned    mseq[16];
    logic [7:0]     pay[32];

    packet_builder #(.NUM_STREAMS(16), .MAX_PAYLOAD(32)) dut (
        .clk(clk), .reset(reset),
        .msg_val(msg_val), .msg_ready(msg_ready),
        .msg_stream(msg_stream), .msg_len(msg_len), .msg_data(msg_data),
        .dataOut(dataOut), .dataOut_val(dataOut_val),
        .dataOut_ready(dataOut_ready), .dataOut_last(dataOut_last),
        .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stall stability.
    initial begin
        logic        stall;
        logic [32:0] stall_w;
        logic [32:0] exp;
        stall = 1'b0;
        stall_w = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (msg_err) err_cnt++;
                if (stall) chk("hold", {30'b0, dataOut_val, dataOut_last, dataOut}, {30'b0, 1'b1, stall_w});
                if (dataOut_val && dataOut_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $error("FAIL spurious_word: got %0h expected none", dataOut);
                    end else begin
                        exp = q.pop_front();
                        chk("word", {31'b0, dataOut_last, dataOut}, {31'b0, exp});
                        got_log.push_back(dataOut);
                    end
                end
                stall   = dataOut_val && !dataOut_ready;
                stall_w = {dataOut_last, dataOut};
            end
        end
    end

    task automatic reset_model();
        for (int s = 0; s < 16; s++) mseq[s] = 1;
        q.delete();
    endtask

    // Present one message; scoreboard is loaded from the bench's own model.
    task automatic send_start(input int s, input int len);
        logic [15:0] l;
        logic [31:0] sq;
        int          nw;
        logic [7:0]  b[4];
        bit          ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (msg_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("ready_timeout", 0, 1);
        msg_stream = 16'(s);
        msg_len    = 6'(len);
        for (int k = 0; k < 32; k++) msg_data[8*k +: 8] = (k < len) ? pay[k] : 8'($urandom);
        msg_val = 1'b1;
        if (s < 16 && len <= 32) begin
            l  = 16'(8 + len);
            sq = mseq[s];
            mseq[s] = mseq[s] + 1;
            q.push_back({1'b0, l[7:0], l[15:8], msg_stream[7:0], msg_stream[15:8]});
            q.push_back({(len == 0), sq[7:0], sq[15:8], sq[23:16], sq[31:24]});
            nw = (len + 3) / 4;
            for (int i = 0; i < nw; i++) begin
                for (int j = 0; j < 4; j++) b[j] = (4*i + j < len) ? pay[4*i + j] : 8'h00;
                q.push_back({(i == nw - 1), b[0], b[1], b[2], b[3]});
            end
        end
        @(posedge clk); #1;
        msg_val    = 1'b0;
        msg_stream = 16'($urandom);
        msg_len    = 6'($urandom);
        msg_data   = {8{$urandom}};
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0 && !dataOut_val) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    initial begin
        reset_model();
        #2 reset = 1'b1;
        #1;
        chk("rst_ready", msg_ready, 0);
        chk("rst_val",   dataOut_val, 0);
        chk("rst_last",  dataOut_last, 0);
        chk("rst_data",  dataOut, 0);
        chk("rst_err",   msg_err, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("ready_low_after_rst", msg_ready, 0);
        @(posedge clk); #1;
        chk("ready_rise", msg_ready, 1);

        // Stream 12, 12 bytes 00..0B.
        for (int k = 0; k < 32; k++) pay[k] = 8'(k);
        got_log.delete();
        send_start(12, 12);
        wait_done();
        chk("t1_w0", got_log[0], 32'h14000C00);
        chk("t1_w1", got_log[1], 32'h01000000);
        chk("t1_w2", got_log[2], 32'h00010203);
        chk("t1_w3", got_log[3], 32'h04050607);
        chk("t1_w4", got_log[4], 32'h08090A0B);

        // Stream 13, 17 bytes, with a stall on SEQ then toggling ready.
        for (int k = 0; k < 32; k++) pay[k] = 8'($urandom);
        got_log.delete();
        send_start(13, 17);
        @(posedge clk); #1;
        dataOut_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_ready", msg_ready, 0);
        end
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0) break;
            chk("busy_ready", msg_ready, 0);
            dataOut_ready = ~dataOut_ready;
            @(posedge clk); #1;
        end
        dataOut_ready = 1'b1;
        wait_done();
        chk("t2_w0", got_log[0], 32'h19000D00);
        chk("t2_w6", got_log[6], {pay[16], 24'h0});
        chk("t2_cnt", got_log.size(), 7);

        // Stream 14, three empty messages.
        for (int n = 1; n <= 3; n++) begin
            got_log.delete();
            send_start(14, 0);
            wait_done();
            chk("s14_seq", got_log[1], {8'(n), 24'h0});
            chk("s14_cnt", got_log.size(), 2);
        end
        // Stream 12 still on seq 2.
        got_log.delete();
        send_start(12, 4);
        wait_done();
        chk("s12_seq2", got_log[1], 32'h02000000);

        // Rejected messages: bad stream, then bad length.
        send_start(16, 4);
        chk("err_stream", msg_err, 1);
        chk("err_ready", msg_ready, 1);
        @(posedge clk); #1;
        chk("err_stream_pulse", msg_err, 0);
        chk("err_noval", dataOut_val, 0);
        send_start(3, 33);
        chk("err_len", msg_err, 1);
        @(posedge clk); #1;
        chk("err_len_pulse", msg_err, 0);
        got_log.delete();
        send_start(12, 1);
        wait_done();
        chk("s12_seq3", got_log[1], 32'h03000000);

        // Reset during PAY of a 32-byte packet.
        send_start(5, 32);
        repeat (2) @(posedge clk);
        #1 chk("pay_active", dataOut_val, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_val", dataOut_val, 0);
        chk("mid_rst_last", dataOut_last, 0);
        reset_model();
        @(posedge clk); #1 reset = 1'b0;
        got_log.delete();
        send_start(12, 0);
        wait_done();
        chk("post_rst_seq", got_log[1], 32'h01000000);

        repeat (3) @(posedge clk);
        #1;
        chk("err_total", err_cnt, 2);
        chk("q_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
